// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// the per-stage control bundle and the hazard-combining rule.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        FAULT    = 2'd3
    } pc_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stall_flush_t;

    localparam int WAIT_CNT_W = 8;

    // Bit order follows the struct: stall_f..stall_m, flush_d..flush_w.
    localparam stall_flush_t SF_NONE   = 8'b0000_0000;
    localparam stall_flush_t SF_FREEZE = 8'b1111_0001;
    localparam stall_flush_t SF_START  = 8'b1000_1111;

    function automatic stall_flush_t hazard_ctrl(
        input logic ldstall,
        input logic pc_wr,
        input logic br_taken
    );
        stall_flush_t c;
        c         = SF_NONE;
        c.stall_f = ldstall | pc_wr;
        c.stall_d = ldstall;
        c.flush_e = ldstall | br_taken;
        c.flush_d = pc_wr | br_taken;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage core: combines hazard requests,
// freezes the pipe on data-memory misses and recovers from memory timeouts.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ldstall_req,
    input  logic             pc_wr_pending,
    input  logic             branch_taken_e,
    input  logic             mem_req_m,
    input  logic             mem_ack_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE    = WAIT_CNT_W'(1);

    pc_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    stall_flush_t           ctrl;
    logic                   fault_pulse;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ctrl        = SF_NONE;
        fault_pulse = 1'b0;
        unique case (state_q)
            START: begin
                ctrl    = SF_START;
                state_d = RUN;
            end
            RUN: begin
                if (mem_req_m && !mem_ack_m) begin
                    ctrl       = SF_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    ctrl = hazard_ctrl(ldstall_req, pc_wr_pending, branch_taken_e);
                end
            end
            MEM_WAIT: begin
                // An ack on the timeout cycle still completes the access.
                if (mem_ack_m) begin
                    ctrl    = hazard_ctrl(ldstall_req, pc_wr_pending, branch_taken_e);
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    ctrl    = SF_FREEZE;
                    state_d = FAULT;
                end else begin
                    ctrl       = SF_FREEZE;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FAULT: begin
                ctrl        = SF_START;
                fault_pulse = 1'b1;
                state_d     = RUN;
            end
            default: begin
                ctrl    = SF_START;
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= START;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stall_f   = ctrl.stall_f;
    assign stall_d   = ctrl.stall_d;
    assign stall_e   = ctrl.stall_e;
    assign stall_m   = ctrl.stall_m;
    assign flush_d   = ctrl.flush_d;
    assign flush_e   = ctrl.flush_e;
    assign flush_m   = ctrl.flush_m;
    assign flush_w   = ctrl.flush_w;
    assign mem_fault = fault_pulse;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (reset),
        .inc  (ctrl.stall_f),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    // Output vector order: stall_f,d,e,m, flush_d,e,m,w, mem_fault
    localparam logic [8:0] O_NONE   = 9'b0000_0000_0;
    localparam logic [8:0] O_START  = 9'b1000_1111_0;
    localparam logic [8:0] O_FREEZE = 9'b1111_0001_0;
    localparam logic [8:0] O_FAULT  = 9'b1000_1111_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic ld = 1'b0, pc = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w, mem_fault;
    logic [CW-1:0] cyc;
    logic [8:0] outs;

    assign outs = {stall_f, stall_d, stall_e, stall_m,
                   flush_d, flush_e, flush_m, flush_w, mem_fault};

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ldstall_req   (ld),
        .pc_wr_pending (pc),
        .branch_taken_e(br),
        .mem_req_m     (req),
        .mem_ack_m     (ack),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .flush_w       (flush_w),
        .mem_fault     (mem_fault),
        .stall_cycles  (cyc)
    );

    // ---------------- behavioural reference model ----------------
    bit m_start, m_fault, m_wait;
    int m_frozen;   // frozen cycles spent on the current access
    int m_cnt;

    function automatic logic [8:0] haz(input logic l, input logic p, input logic b);
        return {l | p, l, 1'b0, 1'b0, p | b, l | b, 3'b000};
    endfunction

    function automatic logic [8:0] model_out();
        if (m_start) return O_START;
        if (m_fault) return O_FAULT;
        if (m_wait)  return ack ? haz(ld, pc, br) : O_FREEZE;
        if (req && !ack) return O_FREEZE;
        return haz(ld, pc, br);
    endfunction

    task automatic model_step(input logic [8:0] e);
        if (e[8]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_start) begin
            m_start = 0;
        end else if (m_fault) begin
            m_fault = 0;
        end else if (m_wait) begin
            if (ack) begin
                m_wait = 0;
            end else begin
                m_frozen++;
                // a fault follows once TO+1 frozen cycles pass without ack
                if (m_frozen == TO + 1) begin
                    m_wait  = 0;
                    m_fault = 1;
                end
            end
        end else if (req && !ack) begin
            m_wait   = 1;
            m_frozen = 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic l, input logic p, input logic b,
                          input logic rq, input logic ak);
        ld = l; pc = p; br = b; req = rq; ack = ak;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in RUN with stall_cycles == 1, at posedge+1.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        #2;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_START); end
        checks++;
        if (cyc !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cyc); end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL start_outs: got %b expected %b", outs, O_START); end
        tick();
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL run_outs: got %b expected %b", outs, O_NONE); end
        checks++;
        if (cyc !== 4'd1) begin errors++; $display("FAIL release_cnt: got %0d expected 1", cyc); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        apply_reset();
        set_in(1, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 9'b1100_0100_0) begin errors++; $display("FAIL loaduse_outs: got %b expected %b", outs, 9'b110001000); end
        tick();
        checks++;
        if (cyc !== 4'd2) begin errors++; $display("FAIL loaduse_cnt: got %0d expected 2", cyc); end
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL loaduse_after: got %b expected %b", outs, O_NONE); end
        tick();
        checks++;
        if (cyc !== 4'd2) begin errors++; $display("FAIL loaduse_cnt_hold: got %0d expected 2", cyc); end
        $display("test_load_use done");
    endtask

    task automatic test_branch_pc();
        apply_reset();
        set_in(0, 1, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 9'b1000_1100_0) begin errors++; $display("FAIL br_pc_outs: got %b expected %b", outs, 9'b100011000); end
        tick();
        set_in(1, 0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 9'b1100_1100_0) begin errors++; $display("FAIL ld_br_outs: got %b expected %b", outs, 9'b110011000); end
        tick();
        set_in(0, 0, 0, 0, 0);
        $display("test_branch_pc done");
    endtask

    task automatic test_mem_wait();
        apply_reset();
        set_in(0, 0, 0, 1, 1);
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL mem_hit_outs: got %b expected %b", outs, O_NONE); end
        tick();
        checks++;
        if (cyc !== 4'd1) begin errors++; $display("FAIL mem_hit_cnt: got %0d expected 1", cyc); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, (i > 0), 1, 0);
            #1;
            checks++;
            if (outs !== O_FREEZE) begin errors++; $display("FAIL mem_wait_outs[%0d]: got %b expected %b", i, outs, O_FREEZE); end
            tick();
        end
        set_in(0, 0, 1, 1, 1);
        #1;
        checks++;
        if (outs !== 9'b0000_1100_0) begin errors++; $display("FAIL mem_release_outs: got %b expected %b", outs, 9'b000011000); end
        tick();
        checks++;
        if (cyc !== 4'd4) begin errors++; $display("FAIL mem_wait_cnt: got %0d expected 4", cyc); end
        set_in(0, 0, 0, 0, 0);
        $display("test_mem_wait done");
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < TO + 1; i++) begin
            set_in(1, 0, 1, 1, 0);
            #1;
            checks++;
            if (outs !== O_FREEZE) begin errors++; $display("FAIL timeout_frozen[%0d]: got %b expected %b", i, outs, O_FREEZE); end
            tick();
        end
        set_in(0, 0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_FAULT) begin errors++; $display("FAIL timeout_fault: got %b expected %b", outs, O_FAULT); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL timeout_recover: got %b expected %b", outs, O_NONE); end
        checks++;
        if (cyc !== 4'd7) begin errors++; $display("FAIL timeout_cnt: got %0d expected 7", cyc); end
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_ack_at_timeout();
        apply_reset();
        for (int i = 0; i < TO; i++) begin
            set_in(0, 0, 0, 1, 0);
            tick();
        end
        set_in(0, 0, 0, 1, 1);
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL ack_to_outs: got %b expected %b", outs, O_NONE); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL ack_to_nofault: got %b expected %b", outs, O_NONE); end
        checks++;
        if (cyc !== 4'd5) begin errors++; $display("FAIL ack_to_cnt: got %0d expected 5", cyc); end
        tick();
        $display("test_ack_at_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        set_in(0, 0, 0, 1, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL midwait_reset_outs: got %b expected %b", outs, O_START); end
        checks++;
        if (cyc !== 4'd0) begin errors++; $display("FAIL midwait_reset_cnt: got %0d expected 0", cyc); end
        tick();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL midwait_restart: got %b expected %b", outs, O_NONE); end
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_saturation();
        int exp_cnt;
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            set_in(0, 1, 0, 0, 0);
            #1;
            checks++;
            if (outs !== 9'b1000_1000_0) begin errors++; $display("FAIL sat_outs[%0d]: got %b expected %b", i, outs, 9'b100010000); end
            tick();
            exp_cnt = (1 + i > CMAX) ? CMAX : 1 + i;
            checks++;
            if (cyc !== CW'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, cyc, exp_cnt); end
        end
        set_in(0, 0, 0, 0, 0);
        $display("test_saturation done");
    endtask

    task automatic test_random();
        logic [8:0] e;
        apply_reset();
        m_start = 0; m_fault = 0; m_wait = 0; m_frozen = 0; m_cnt = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #1;
                checks++;
                if (outs !== O_START) begin errors++; $display("FAIL rand_reset_outs[%0d]: got %b expected %b", i, outs, O_START); end
                m_start = 1; m_fault = 0; m_wait = 0; m_frozen = 0; m_cnt = 0;
                reset = 1'b0;
            end
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0);
            #1;
            e = model_out();
            checks++;
            if (outs !== e) begin errors++; $display("FAIL rand_outs[%0d]: got %b expected %b", i, outs, e); end
            checks++;
            if (cyc !== CW'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, cyc, m_cnt); end
            tick();
            model_step(e);
        end
        set_in(0, 0, 0, 0, 0);
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_pc();
        test_mem_wait();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
